// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, rounding modes and status flags for the minifloat datapath
package fp_pkg;
  localparam int ROUND_TRUNC = 0;
  localparam int ROUND_RNE = 1;
  typedef struct packed {
    logic ovf;
    logic uf;
  } fp_flags_t;
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction
  function automatic int fp_prod_w(input int man_w);
    return 2 * man_w + 2;
  endfunction
  function automatic int fp_esum_w(input int exp_w);
    return exp_w + 2;
  endfunction
endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: normalise, round, saturate/flush and pack a raw product
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4,
  parameter int ROUND = ROUND_TRUNC,
  localparam int W = fp_width(EXP_W, MAN_W),
  localparam int PW = fp_prod_w(MAN_W),
  localparam int ESW = fp_esum_w(EXP_W)
) (
  input  logic           sign,
  input  logic           zero,
  input  logic [ESW-1:0] e,
  input  logic [PW-1:0]  prod,
  output logic [W-1:0]   p,
  output fp_flags_t      flags
);
  logic hi, guard, sticky, inc, carry;
  logic [MAN_W-1:0] man, man_r;
  logic [ESW-1:0] e_f;
  // e_f is two's complement: top bit flags underflow, the next one overflow
  always_comb begin
    hi = prod[PW-1];
    man = hi ? prod[2*MAN_W:MAN_W+1] : prod[2*MAN_W-1:MAN_W];
    guard = hi ? prod[MAN_W] : prod[MAN_W-1];
    sticky = hi ? |prod[MAN_W-1:0] : |prod[MAN_W-2:0];
    inc = (ROUND == ROUND_RNE) && guard && (sticky || man[0]);
    {carry, man_r} = {1'b0, man} + (MAN_W+1)'(inc);
    e_f = e + ESW'(hi) + ESW'(carry);
    flags.uf = !zero && e_f[ESW-1];
    flags.ovf = !zero && !e_f[ESW-1] && e_f[EXP_W];
    p = (zero || flags.uf) ? '0 : flags.ovf ? {sign, {(W-1){1'b1}}} : {sign, e_f[EXP_W-1:0], man_r};
  end
endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage minifloat multiplier with valid/ready backpressure
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4,
  parameter int ROUND = ROUND_TRUNC,
  localparam int W = fp_width(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_p,
  output logic         out_ovf,
  output logic         out_uf
);
  localparam int PW = fp_prod_w(MAN_W);
  localparam int ESW = fp_esum_w(EXP_W);
  localparam int BIAS = fp_bias(EXP_W);
  logic adv1, adv2, adv3, ld1, ld2, ld3;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic sign1_q, sign1_d, zero1_q, zero1_d, sign2_q, sign2_d, zero2_q, zero2_d;
  logic [ESW-1:0] e1_q, e1_d, e2_q, e2_d;
  logic [MAN_W-1:0] ma1_q, ma1_d, mb1_q, mb1_d;
  logic [PW-1:0] prod2_q, prod2_d;
  logic [W-1:0] p3_q, p3_d, rp_p;
  fp_flags_t flags3_q, flags3_d, rp_flags;
  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .ROUND(ROUND)) u_round_pack (
    .sign(sign2_q),
    .zero(zero2_q),
    .e(e2_q),
    .prod(prod2_q),
    .p(rp_p),
    .flags(rp_flags)
  );
  // Each stage moves when empty or when its successor moves, so bubbles collapse
  always_comb begin
    adv3 = !v3_q || out_ready;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;
    ld1 = adv1 && in_valid;
    ld2 = adv2 && v1_q;
    ld3 = adv3 && v2_q;
    v1_d = adv1 ? in_valid : v1_q;
    v2_d = adv2 ? v1_q : v2_q;
    v3_d = adv3 ? v2_q : v3_q;
    sign1_d = ld1 ? in_a[W-1] ^ in_b[W-1] : sign1_q;
    zero1_d = ld1 ? (in_a[W-2:0] == '0 || in_b[W-2:0] == '0) : zero1_q;
    e1_d = ld1 ? ESW'(in_a[W-2:MAN_W]) + ESW'(in_b[W-2:MAN_W]) - ESW'(BIAS) : e1_q;
    ma1_d = ld1 ? in_a[MAN_W-1:0] : ma1_q;
    mb1_d = ld1 ? in_b[MAN_W-1:0] : mb1_q;
    sign2_d = ld2 ? sign1_q : sign2_q;
    zero2_d = ld2 ? zero1_q : zero2_q;
    e2_d = ld2 ? e1_q : e2_q;
    prod2_d = ld2 ? PW'({1'b1, ma1_q}) * PW'({1'b1, mb1_q}) : prod2_q;
    p3_d = ld3 ? rp_p : p3_q;
    flags3_d = ld3 ? rp_flags : flags3_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      sign1_q <= 1'b0;
      zero1_q <= 1'b0;
      e1_q <= '0;
      ma1_q <= '0;
      mb1_q <= '0;
      sign2_q <= 1'b0;
      zero2_q <= 1'b0;
      e2_q <= '0;
      prod2_q <= '0;
      p3_q <= '0;
      flags3_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      sign1_q <= sign1_d;
      zero1_q <= zero1_d;
      e1_q <= e1_d;
      ma1_q <= ma1_d;
      mb1_q <= mb1_d;
      sign2_q <= sign2_d;
      zero2_q <= zero2_d;
      e2_q <= e2_d;
      prod2_q <= prod2_d;
      p3_q <= p3_d;
      flags3_q <= flags3_d;
    end
  end
  assign in_ready = adv1;
  assign out_valid = v3_q;
  assign out_p = p3_q;
  assign out_ovf = flags3_q.ovf;
  assign out_uf = flags3_q.uf;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed and random checks of both rounding variants against a value-level model
module tb_fp_mult_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [7:0] in_a, in_b;
  logic in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1, uf0, uf1;
  logic [7:0] p0, p1;
  int n_assert = 0;
  int n_fail = 0;
  typedef struct { logic [9:0] r0; logic [9:0] r1; } exp_t;
  exp_t q[$];
  typedef struct { logic [7:0] a, b, e0, e1; logic ovf, uf; } vec_t;
  vec_t vecs[9] = '{
    '{8'h38, 8'h38, 8'h42, 8'h42, 1'b0, 1'b0},
    '{8'hB8, 8'h38, 8'hC2, 8'hC2, 1'b0, 1'b0},
    '{8'h30, 8'h55, 8'h55, 8'h55, 1'b0, 1'b0},
    '{8'h00, 8'h55, 8'h00, 8'h00, 1'b0, 1'b0},
    '{8'h80, 8'hD3, 8'h00, 8'h00, 1'b0, 1'b0},
    '{8'h33, 8'h33, 8'h36, 8'h37, 1'b0, 1'b0},
    '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0},
    '{8'hFF, 8'h7F, 8'hFF, 8'hFF, 1'b1, 1'b0},
    '{8'h08, 8'h08, 8'h00, 8'h00, 1'b0, 1'b1}
  };

  always #5 clk = ~clk;

  fp_mult_pipe #(.EXP_W(3), .MAN_W(4), .ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid0), .out_ready(out_ready), .out_p(p0), .out_ovf(ovf0), .out_uf(uf0)
  );
  fp_mult_pipe #(.EXP_W(3), .MAN_W(4), .ROUND(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid1), .out_ready(out_ready), .out_p(p1), .out_ovf(ovf1), .out_uf(uf1)
  );

  // Value-level model: integer significand product, then scale to a 5-bit significand
  function automatic logic [9:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input bit rne);
    int m, ue, sh, qq, r, half, be;
    logic s;
    if (a[6:0] == 7'd0 || b[6:0] == 7'd0) return 10'd0;
    s = a[7] ^ b[7];
    m = (16 + int'(a[3:0])) * (16 + int'(b[3:0]));
    ue = int'(a[6:4]) + int'(b[6:4]) - 6;
    sh = 4;
    if (m >= 512) begin sh = 5; ue++; end
    qq = m >> sh;
    r = m % (1 << sh);
    half = 1 << (sh - 1);
    if (rne && (r > half || (r == half && qq % 2 == 1))) qq++;
    if (qq == 32) begin qq = 16; ue++; end
    be = ue + 3;
    if (be > 7) return {s, 7'h7F, 2'b10};
    if (be < 0) return 10'b01;
    return {s, be[2:0], qq[3:0], 2'b00};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (in_valid && in_ready0) q.push_back('{ref_mul(in_a, in_b, 1'b0), ref_mul(in_a, in_b, 1'b1)});
    if (out_valid0 && out_ready) begin
      if (q.size() == 0) check("spurious_out", 12'(out_valid0), 12'd0);
      else begin
        e = q.pop_front();
        check("rand_trunc", {2'b0, p0, ovf0, uf0}, {2'b0, e.r0});
        check("rand_rne", {2'b0, p1, ovf1, uf1}, {2'b0, e.r1});
        check("rand_valid_rne", 12'(out_valid1), 12'd1);
      end
    end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = 8'h00;
    in_b = 8'h00;
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_valid", 12'(out_valid0), 12'd0);
    check("rst_out", {2'b0, p0, ovf0, uf0}, 12'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 12'(in_ready0), 12'd1);
    next_cycle();

    foreach (vecs[i]) begin
      in_a = vecs[i].a;
      in_b = vecs[i].b;
      in_valid = 1'b1;
      @(negedge clk);
      check("dir_accept", 12'(in_ready0), 12'd1);
      next_cycle();
      in_valid = 1'b0;
      repeat (2) begin
        @(negedge clk);
        check("dir_latency", 12'(out_valid0), 12'd0);
        next_cycle();
      end
      @(negedge clk);
      check("dir_valid", 12'(out_valid0), 12'd1);
      check("dir_trunc", {2'b0, p0, ovf0, uf0}, {2'b0, vecs[i].e0, vecs[i].ovf, vecs[i].uf});
      check("dir_rne", {2'b0, p1, ovf1, uf1}, {2'b0, vecs[i].e1, vecs[i].ovf, vecs[i].uf});
      next_cycle();
    end

    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = (i == 0) ? 8'h38 : (i == 1) ? 8'hB8 : (i == 2) ? 8'h33 : 8'h30;
      in_b = (i == 0) ? 8'h38 : (i == 1) ? 8'h38 : (i == 2) ? 8'h33 : 8'h55;
      @(negedge clk);
      check("bp_in_ready", 12'(in_ready0), (i < 3) ? 12'd1 : 12'd0);
      next_cycle();
    end
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("bp_hold_valid", 12'(out_valid0), 12'd1);
      check("bp_hold_p", {4'b0, p0}, 12'h042);
      next_cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_drain_valid", 12'(out_valid0), 12'd1);
      check("bp_drain_trunc", {4'b0, p0}, (i == 0) ? 12'h042 : (i == 1) ? 12'h0C2 : 12'h036);
      check("bp_drain_rne", {4'b0, p1}, (i == 0) ? 12'h042 : (i == 1) ? 12'h0C2 : 12'h037);
      next_cycle();
    end
    @(negedge clk);
    check("bp_no_dup", 12'(out_valid0), 12'd0);
    next_cycle();

    in_valid = 1'b1;
    in_a = 8'h38;
    in_b = 8'h38;
    next_cycle();
    in_a = 8'hB8;
    next_cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check("mid_rst_valid", 12'(out_valid0), 12'd0);
    check("mid_rst_p", {4'b0, p0}, 12'd0);
    rst = 1'b0;
    next_cycle();
    repeat (5) begin
      @(negedge clk);
      check("mid_rst_stale", 12'(out_valid0 | out_valid1), 12'd0);
      next_cycle();
    end

    for (int i = 0; i < 20000; i++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() != 0; k++) tick();
    check("drain_empty", 12'(q.size()), 12'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
